param_accum_alu: RTL

Parametrised, pipelined successor to the 8-bit PowerALU.
- WIDTH-bit operands with a two-stage pipeline: operand capture, then execute/result register.
- Valid/ready input handshake, full flag set (carry, overflow, zero, negative), and an internal accumulator that can replace operand A.
- Multi-cycle shift-add multiplier opcode.
- Sits between the register file/sequencer and the writeback path.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/seq_multiplier.sv | 61 ++++++
 rtl/param_accum_alu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: opcodes, FSM states, CMP result bits.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  // 4-bit operation select
  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_INCA  = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_ADC   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_DECA  = 4'd5;
  localparam logic [3:0] OP_INCB  = 4'd6;
  localparam logic [3:0] OP_NAND  = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd10;
  localparam logic [3:0] OP_XOR   = 4'd11;
  localparam logic [3:0] OP_XNOR  = 4'd12;
  localparam logic [3:0] OP_CMP   = 4'd13;
  localparam logic [3:0] OP_NOTA  = 4'd14;
  localparam logic [3:0] OP_MUL   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  // Bit positions of the unsigned compare flags in the CMP result
  localparam int CMP_EQ_BIT = 0;
  localparam int CMP_LT_BIT = 1;
  localparam int CMP_GT_BIT = 2;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per clock.
// Latency: start at edge n -> done_o high for the cycle after edge n+WIDTH-1 (WIDTH iterations).
// Backpressure: none; start_i is only raised by the owner when idle, product holds until next start.
// Ports: clk/rst_n (async active-low), start_i, a_i/b_i operands, done_o pulse, prod_o 2*WIDTH product.
module seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;

  // The start edge already folds in bit 0 of the multiplier, so only
  // WIDTH-1 further iterations remain after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        prod_q   <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
        mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
        mplier_q <= b_i >> 1;
        cnt_q    <= CNT_W'(WIDTH - 1);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) begin
          prod_q <= prod_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/param_accum_alu.sv
// Two-stage ALU with accumulator, full flags and a multi-cycle MUL opcode.
// Latency: 1 edge after accept for single-cycle ops, WIDTH+1 edges for MUL; out_valid pulses once.
// Backpressure: in_ready drops for the whole MUL and while reset is low; no request queueing.
// Ports: in_valid/in_ready handshake with opcode/a/b/acc_sel/acc_en, live acc_clr;
//        out_valid + alu_out/alu_cout/alu_of/alu_zero/alu_neg result, acc_out accumulator.
module param_accum_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_sel,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_cout,
  output logic             alu_of,
  output logic             alu_zero,
  output logic             alu_neg,
  output logic [WIDTH-1:0] acc_out
);

  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic               accept;
  logic               exec_vld;

  logic [3:0]         s1_op_q;
  logic [WIDTH-1:0]   s1_a_q;
  logic [WIDTH-1:0]   s1_b_q;
  logic               s1_acc_sel_q;
  logic               s1_acc_en_q;
  logic               mul_start_q;

  logic [WIDTH-1:0]   acc_q;
  logic               carry_hist_q;

  logic [WIDTH-1:0]   op_a, op_b, res;
  logic [WIDTH:0]     sum;
  logic               res_cout, res_of;

  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic               out_valid_q;
  logic [WIDTH-1:0]   alu_out_q;
  logic               cout_q, of_q, zero_q, neg_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_EXEC: begin
        if (accept) state_d = (opcode == OP_MUL) ? ST_MUL : ST_EXEC;
        else        state_d = ST_IDLE;
      end
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready is gated by the reset pin itself so it reads 0 the moment reset asserts.
  always_comb begin
    in_ready = reset && (state_q != ST_MUL);
    accept   = in_valid && in_ready;
    exec_vld = (state_q == ST_EXEC) || ((state_q == ST_MUL) && mul_done);
  end

  // ---------------- Stage 1: operand capture ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_acc_sel_q <= 1'b0;
      s1_acc_en_q  <= 1'b0;
      mul_start_q  <= 1'b0;
    end else begin
      mul_start_q <= accept && (opcode == OP_MUL);
      if (accept) begin
        s1_op_q      <= opcode;
        s1_a_q       <= a;
        s1_b_q       <= b;
        s1_acc_sel_q <= acc_sel;
        s1_acc_en_q  <= acc_en;
      end
    end
  end

  // ---------------- Stage 2: execute ----------------
  // Operand A reads the live accumulator here, after the previous op has
  // written it, so dependent back-to-back ops need no forwarding.
  always_comb begin
    op_a     = s1_acc_sel_q ? acc_q : s1_a_q;
    op_b     = s1_b_q;
    sum      = '0;
    res      = '0;
    res_cout = 1'b0;
    res_of   = 1'b0;
    case (s1_op_q)
      OP_PASSA: res = op_a;
      OP_INCA: begin
        sum = {1'b0, op_a} + (WIDTH+1)'(1);
        res = sum[MSB:0]; res_cout = sum[WIDTH];
        res_of = ~op_a[MSB] & res[MSB];
      end
      OP_ADD, OP_ADC: begin
        sum = {1'b0, op_a} + {1'b0, op_b}
            + (WIDTH+1)'((s1_op_q == OP_ADC) ? carry_hist_q : 1'b0);
        res = sum[MSB:0]; res_cout = sum[WIDTH];
        res_of = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        // A + ~B + 1: carry out is the no-borrow flag
        sum = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
        res = sum[MSB:0]; res_cout = sum[WIDTH];
        res_of = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_DECA: begin
        sum = {1'b0, op_a} + {1'b0, {WIDTH{1'b1}}};
        res = sum[MSB:0]; res_cout = sum[WIDTH];
        res_of = op_a[MSB] & ~res[MSB];
      end
      OP_INCB: begin
        sum = {1'b0, op_b} + (WIDTH+1)'(1);
        res = sum[MSB:0]; res_cout = sum[WIDTH];
        res_of = ~op_b[MSB] & res[MSB];
      end
      OP_NAND: res = ~(op_a & op_b);
      OP_AND:  res = op_a & op_b;
      OP_OR:   res = op_a | op_b;
      OP_NOR:  res = ~(op_a | op_b);
      OP_XOR:  res = op_a ^ op_b;
      OP_XNOR: res = ~(op_a ^ op_b);
      OP_CMP: begin
        res[CMP_GT_BIT] = op_a > op_b;
        res[CMP_LT_BIT] = op_a < op_b;
        res[CMP_EQ_BIT] = op_a == op_b;
      end
      OP_NOTA: res = ~op_a;
      OP_MUL: begin
        res      = mul_prod[MSB:0];
        res_cout = |mul_prod[2*WIDTH-1:WIDTH];
        res_of   = res_cout;
      end
      default: res = '0;
    endcase
  end

  seq_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (mul_start_q),
    .a_i     (op_a),
    .b_i     (op_b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // ---------------- Result, carry history and accumulator ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      alu_out_q    <= '0;
      cout_q       <= 1'b0;
      of_q         <= 1'b0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      carry_hist_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      out_valid_q <= exec_vld;
      if (exec_vld) begin
        alu_out_q    <= res;
        cout_q       <= res_cout;
        of_q         <= res_of;
        zero_q       <= (res == '0);
        neg_q        <= res[MSB];
        carry_hist_q <= res_cout;
      end
      if (acc_clr)                        acc_q <= '0;
      else if (exec_vld && s1_acc_en_q)   acc_q <= res;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign alu_cout  = cout_q;
  assign alu_of    = of_q;
  assign alu_zero  = zero_q;
  assign alu_neg   = neg_q;
  assign acc_out   = acc_q;

endmodule
